fmul32_round: RTL and testbench

FMUL32_ROUND -- requirements
Module: fmul32_round

---
 rtl/fmul32_pkg.sv | 28 ++
 rtl/fmul32_lzc.sv | 14 +
 rtl/fmul32_round.sv | 162 ++++++++++++++++
 tb/tb_fmul32_round.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmul32_pkg.sv
// Shared constants and enumerations for the fmul32 round/pack stage.
package fmul32_pkg;

  localparam int unsigned MARK_NAN    = 0;
  localparam int unsigned MARK_ZERO   = 1;
  localparam int unsigned MARK_NORM   = 2;
  localparam int unsigned MARK_DENORM = 3;
  localparam int unsigned MARK_INF    = 4;

  localparam int unsigned BIAS = 127;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] MAXF = 32'h7F7F_FFFF;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rmode_e;

  typedef enum logic [1:0] {
    CLS_NUM,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } cls_e;

endpackage

// File: rtl/fmul32_lzc.sv
// 48-bit leading-zero counter; an all-zero input reports 48.
module fmul32_lzc (
  input  logic [47:0] i_data,
  output logic [5:0]  o_count
);

  always_comb begin
    o_count = 6'd48;
    for (int unsigned i = 0; i < 48; i++) begin
      if (i_data[i]) o_count = 6'(47 - i);
    end
  end

endmodule

// File: rtl/fmul32_round.sv
// Normalise (S1) and round/pack (S2) stage of a single-precision multiplier,
// with valid/ready handshakes on both sides.
module fmul32_round
  import fmul32_pkg::*;
#(
  parameter bit SUBNORM_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [47:0] in_prod,
  input  logic [4:0]  in_mark,
  input  logic [1:0]  in_rmode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [2:0]  flags
);

  localparam logic signed [10:0] EXP_OVF = 11'(2 * BIAS + 1);

  logic               w_s1_adv;
  logic               r1_valid, r1_sign, r1_tiny, r1_sticky;
  cls_e               r1_cls;
  rmode_e             r1_rmode;
  logic signed [10:0] r1_exp;
  logic [47:0]        r1_mant;
  logic               r2_valid;
  logic [31:0]        r2_result;
  logic [2:0]         r2_flags;

  assign w_s1_adv  = ~r2_valid | out_ready;
  assign in_ready  = ~r1_valid | w_s1_adv;
  assign out_valid = r2_valid;
  assign result    = r2_result;
  assign flags     = r2_flags;

  logic [5:0]         w_lz;
  logic [47:0]        w_norm, w_den, w_mask;
  logic signed [10:0] w_e, w_sh;
  logic [4:0]         w_shamt;
  logic               w_tiny;
  cls_e               w_cls;

  fmul32_lzc u_lzc (
    .i_data  (in_prod),
    .o_count (w_lz)
  );

  always_comb begin
    w_norm  = in_prod << w_lz;
    // leading one at bit 47 means one position above the nominal bit 46
    w_e     = $signed({in_exp[9], in_exp}) + 11'sd1 - $signed({5'd0, w_lz});
    w_tiny  = (w_e <= 11'sd0);
    w_sh    = 11'sd1 - w_e;
    w_shamt = (w_sh > 11'sd26) ? 5'd26 : w_sh[4:0];
    w_mask  = (48'd1 << w_shamt) - 48'd1;
    w_den   = w_norm >> w_shamt;
    if (in_mark[MARK_NAN])      w_cls = CLS_NAN;
    else if (in_mark[MARK_INF]) w_cls = CLS_INF;
    else if (in_mark[MARK_ZERO] ||
             ((in_mark[MARK_NORM] || in_mark[MARK_DENORM]) && in_prod == '0))
                                w_cls = CLS_ZERO;
    else                        w_cls = CLS_NUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid  <= 1'b0;
      r1_sign   <= 1'b0;
      r1_tiny   <= 1'b0;
      r1_sticky <= 1'b0;
      r1_cls    <= CLS_NUM;
      r1_rmode  <= RM_RNE;
      r1_exp    <= '0;
      r1_mant   <= '0;
    end else if (in_ready) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_sign   <= in_sign;
        r1_cls    <= w_cls;
        r1_rmode  <= rmode_e'(in_rmode);
        r1_tiny   <= w_tiny;
        r1_exp    <= w_tiny ? '0 : w_e;
        r1_mant   <= w_tiny ? w_den : w_norm;
        r1_sticky <= w_tiny & (|(w_norm & w_mask));
      end
    end
  end

  logic               w_guard, w_stk, w_inexact, w_inc, w_ovf, w_use_inf;
  logic [24:0]        w_sum;
  logic signed [10:0] w_eo;
  logic [22:0]        w_frac;
  logic [31:0]        w_res;
  logic [2:0]         w_flg;

  always_comb begin
    w_guard   = r1_mant[23];
    w_stk     = (|r1_mant[22:0]) | r1_sticky;
    w_inexact = w_guard | w_stk;
    case (r1_rmode)
      RM_RNE:  w_inc = w_guard & (w_stk | r1_mant[24]);
      RM_RTZ:  w_inc = 1'b0;
      RM_RUP:  w_inc = ~r1_sign & w_inexact;
      default: w_inc = r1_sign & w_inexact;
    endcase
    w_sum = {1'b0, r1_mant[47:24]} + {24'd0, w_inc};
    // a subnormal that rounds up into bit 23 becomes the minimum normal
    if (r1_tiny) begin
      w_eo   = w_sum[23] ? 11'sd1 : 11'sd0;
      w_frac = w_sum[22:0];
    end else if (w_sum[24]) begin
      w_eo   = r1_exp + 11'sd1;
      w_frac = w_sum[23:1];
    end else begin
      w_eo   = r1_exp;
      w_frac = w_sum[22:0];
    end
    w_ovf = ~r1_tiny & (w_eo >= EXP_OVF);
    case (r1_rmode)
      RM_RNE:  w_use_inf = 1'b1;
      RM_RTZ:  w_use_inf = 1'b0;
      RM_RUP:  w_use_inf = ~r1_sign;
      default: w_use_inf = r1_sign;
    endcase
    w_res = {r1_sign, w_eo[7:0], w_frac};
    w_flg = {1'b0, r1_tiny & w_inexact, w_inexact};
    if (w_ovf) begin
      w_res = {r1_sign, w_use_inf ? 31'h7F80_0000 : MAXF[30:0]};
      w_flg = 3'b101;
    end
    if (r1_tiny && !SUBNORM_EN) begin
      w_res = {r1_sign, 31'd0};
      w_flg = 3'b011;
    end
    case (r1_cls)
      CLS_NAN:  begin w_res = QNAN;                      w_flg = '0; end
      CLS_INF:  begin w_res = {r1_sign, 8'hFF, 23'd0};   w_flg = '0; end
      CLS_ZERO: begin w_res = {r1_sign, 31'd0};          w_flg = '0; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid  <= 1'b0;
      r2_result <= '0;
      r2_flags  <= '0;
    end else if (w_s1_adv) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_result <= w_res;
        r2_flags  <= w_flg;
      end
    end
  end

endmodule

// File: tb/tb_fmul32_round.sv
// Scoreboard bench for fmul32_round: one subnormal-enabled and one flush-to-zero instance.
module tb_fmul32_round;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [47:0] in_prod = '0;
  logic [4:0]  in_mark = '0;
  logic [1:0]  in_rmode = '0;
  logic        out_ready = 1'b1;
  logic        in_ready_m, out_valid_m, in_ready_f, out_valid_f;
  logic [31:0] result_m, result_f;
  logic [2:0]  flags_m, flags_f;

  int          total = 0;
  int          bad = 0;
  bit          bp_en = 1'b0;
  logic [34:0] q_m[$];
  logic [34:0] q_f[$];
  logic [34:0] mon_m, mon_f;

  localparam logic [4:0] NORM = 5'b00100;

  fmul32_round #(.SUBNORM_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_sign(in_sign), .in_exp(in_exp), .in_prod(in_prod), .in_mark(in_mark),
    .in_rmode(in_rmode), .out_valid(out_valid_m), .out_ready(out_ready),
    .result(result_m), .flags(flags_m)
  );

  fmul32_round #(.SUBNORM_EN(1'b0)) dut_ftz (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_f),
    .in_sign(in_sign), .in_exp(in_exp), .in_prod(in_prod), .in_mark(in_mark),
    .in_rmode(in_rmode), .out_valid(out_valid_f), .out_ready(out_ready),
    .result(result_f), .flags(flags_f)
  );

  initial forever #5 clk = ~clk;

  // Reference: quantise prod*2^(e-173) to the IEEE grid via integer remainder.
  function automatic logic [34:0] model(input logic s, input logic [9:0] ein,
                                        input logic [47:0] p, input logic [4:0] m,
                                        input logic [1:0] rm, input bit sub);
    int          e, msb, d, big_e, ef;
    logic [63:0] q, rem, half;
    logic        up, tiny, inx, inf;
    if (m[0]) return {32'h7FC0_0000, 3'b000};
    if (m[4]) return {s, 8'hFF, 23'd0, 3'b000};
    if (m[1] || p == '0) return {s, 31'd0, 3'b000};
    msb = 0;
    for (int i = 0; i < 48; i++) if (p[i]) msb = i;
    e = int'($signed(ein)) + msb - 46;
    tiny = (e <= 0);
    if (tiny && !sub) return {s, 31'd0, 3'b011};
    big_e = tiny ? 1 : e;
    d = msb - 23 + (big_e - e);
    if (d <= 0) begin
      q = 64'(p) << (-d); rem = '0; half = 64'd1;
    end else if (d > 60) begin
      q = '0; rem = 64'd1; half = 64'd1 << 60;
    end else begin
      q = 64'(p) >> d; rem = 64'(p) & ((64'd1 << d) - 64'd1); half = 64'd1 << (d - 1);
    end
    inx = (rem != '0);
    case (rm)
      2'd0:    up = (rem > half) || (rem == half && q[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = !s && inx;
      default: up = s && inx;
    endcase
    q = q + 64'(up);
    if (q == 64'h100_0000) begin q = 64'h80_0000; big_e++; end
    ef = (q >= 64'h80_0000) ? big_e : 0;
    if (ef >= 255) begin
      inf = (rm == 2'd0) || (rm == 2'd2 && !s) || (rm == 2'd3 && s);
      return {s, inf ? 31'h7F80_0000 : 31'h7F7F_FFFF, 3'b101};
    end
    return {s, 8'(ef), q[22:0], 1'b0, tiny && inx, inx};
  endfunction

  task automatic drive(input logic s, input logic [9:0] e, input logic [47:0] p,
                       input logic [4:0] m, input logic [1:0] rm,
                       input logic [34:0] em, input logic [34:0] ef);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_sign = s; in_exp = e; in_prod = p; in_mark = m; in_rmode = rm;
    out_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    @(negedge clk);
    while (!in_ready_m && n < 50) begin
      @(posedge clk); #1; out_ready = 1'b1;
      @(negedge clk); n++;
    end
    total++;
    if (!in_ready_m) begin
      bad++;
      $display("FAIL accept: in_ready=%b after %0d cycles, want 1", in_ready_m, n);
    end else begin
      q_m.push_back(em);
      q_f.push_back(ef);
    end
  endtask

  task automatic wait_drain();
    @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 40 && (q_m.size() != 0 || q_f.size() != 0); i++) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({out_valid_m, result_m, flags_m, out_valid_f, result_f, flags_f} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b r=%h f=%b / v=%b r=%h f=%b, want all 0",
               out_valid_m, result_m, flags_m, out_valid_f, result_f, flags_f);
    end
    #11 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1/0", in_ready_m, out_valid_m);
    end
  endtask

  task automatic test_directed();
    drive(0, 10'd127, 48'h9000_0000_0000, NORM, 2'd0, {32'h4010_0000, 3'b000}, {32'h4010_0000, 3'b000});
    drive(0, 10'd127, 48'h8000_0080_0000, NORM, 2'd0, {32'h4000_0000, 3'b001}, {32'h4000_0000, 3'b001});
    drive(0, 10'd127, 48'h8000_0080_0000, NORM, 2'd2, {32'h4000_0001, 3'b001}, {32'h4000_0001, 3'b001});
    drive(0, 10'd127, 48'h8000_0080_0000, NORM, 2'd1, {32'h4000_0000, 3'b001}, {32'h4000_0000, 3'b001});
    drive(1, 10'd127, 48'h8000_0080_0000, NORM, 2'd3, {32'hC000_0001, 3'b001}, {32'hC000_0001, 3'b001});
    drive(0, 10'd254, 48'h8000_0000_0000, NORM, 2'd0, {32'h7F80_0000, 3'b101}, {32'h7F80_0000, 3'b101});
    drive(0, 10'd254, 48'h8000_0000_0000, NORM, 2'd1, {32'h7F7F_FFFF, 3'b101}, {32'h7F7F_FFFF, 3'b101});
    drive(1, 10'd254, 48'h8000_0000_0000, NORM, 2'd2, {32'hFF7F_FFFF, 3'b101}, {32'hFF7F_FFFF, 3'b101});
    drive(1, 10'd254, 48'h8000_0000_0000, NORM, 2'd3, {32'hFF80_0000, 3'b101}, {32'hFF80_0000, 3'b101});
    drive(0, 10'd254, 48'h8000_0000_0000, NORM, 2'd3, {32'h7F7F_FFFF, 3'b101}, {32'h7F7F_FFFF, 3'b101});
    drive(0, 10'd253, 48'h8000_0000_0000, NORM, 2'd0, {32'h7F00_0000, 3'b000}, {32'h7F00_0000, 3'b000});
    drive(0, 10'd253, 48'hFFFF_FFFF_FFFF, NORM, 2'd2, {32'h7F80_0000, 3'b101}, {32'h7F80_0000, 3'b101});
    drive(0, 10'h3FE, 48'h4000_0000_0000, NORM, 2'd0, {32'h0010_0000, 3'b000}, {32'h0000_0000, 3'b011});
    drive(0, 10'd127, 48'hFFFF_FF80_0000, NORM, 2'd0, {32'h4080_0000, 3'b001}, {32'h4080_0000, 3'b001});
    drive(0, 10'h3FF, 48'hFFFF_FF80_0000, NORM, 2'd0, {32'h0080_0000, 3'b011}, {32'h0000_0000, 3'b011});
    drive(0, 10'h381, 48'h4000_0000_0000, NORM, 2'd0, {32'h0000_0000, 3'b011}, {32'h0000_0000, 3'b011});
    drive(0, 10'h381, 48'h4000_0000_0000, NORM, 2'd2, {32'h0000_0001, 3'b011}, {32'h0000_0000, 3'b011});
    drive(0, 10'd300, 48'h1234_5678_9ABC, 5'b00001, 2'd0, {32'h7FC0_0000, 3'b000}, {32'h7FC0_0000, 3'b000});
    drive(1, 10'd5,   48'h8000_0000_0000, 5'b10000, 2'd1, {32'hFF80_0000, 3'b000}, {32'hFF80_0000, 3'b000});
    drive(1, 10'd127, 48'h8000_0000_0000, 5'b00010, 2'd0, {32'h8000_0000, 3'b000}, {32'h8000_0000, 3'b000});
    drive(0, 10'd127, 48'h0,              NORM,     2'd2, {32'h0000_0000, 3'b000}, {32'h0000_0000, 3'b000});
    wait_drain();
    total++;
    if (q_m.size() != 0 || q_f.size() != 0) begin
      bad++;
      $display("FAIL drain_directed: pending main=%0d ftz=%0d, want 0", q_m.size(), q_f.size());
    end
  endtask

  task automatic test_random();
    logic [47:0] p;
    logic [9:0]  e;
    logic [4:0]  m;
    logic [1:0]  rm;
    logic        s;
    int          msb;
    bp_en = 1'b1;
    for (int n = 0; n < 80; n++) begin
      msb = (n % 4 == 0) ? int'($urandom_range(10, 45)) : int'($urandom_range(46, 47));
      p = 48'({$urandom(), $urandom()});
      p = p & ((48'd1 << msb) - 48'd1);
      p[msb] = 1'b1;
      if ($urandom_range(0, 1) != 0) e = 10'($urandom_range(1, 254));
      else e = 10'(int'($urandom_range(0, 510)) - 127);
      case ($urandom_range(0, 15))
        0:       m = 5'b00001;
        1:       m = 5'b10000;
        2:       m = 5'b00010;
        3:       m = 5'b01000;
        default: m = NORM;
      endcase
      s  = 1'($urandom_range(0, 1));
      rm = 2'($urandom_range(0, 3));
      drive(s, e, p, m, rm, model(s, e, p, m, rm, 1'b1), model(s, e, p, m, rm, 1'b0));
    end
    bp_en = 1'b0;
    wait_drain();
    total++;
    if (q_m.size() != 0 || q_f.size() != 0) begin
      bad++;
      $display("FAIL drain_random: pending main=%0d ftz=%0d, want 0", q_m.size(), q_f.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] prods[3] = '{48'h9000_0000_0000, 48'h8000_0080_0000, 48'h8000_0000_0000};
    logic [9:0]  exps[3]  = '{10'd127, 10'd127, 10'd254};
    logic [1:0]  rms[3]   = '{2'd0, 2'd2, 2'd1};
    logic [34:0] exps_q[3] = '{{32'h4010_0000, 3'b000}, {32'h4000_0001, 3'b001}, {32'h7F7F_FFFF, 3'b101}};
    int idx = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = 1'b1; in_sign = 1'b0; in_mark = NORM;
      in_prod = prods[idx]; in_exp = exps[idx]; in_rmode = rms[idx];
      @(negedge clk);
      if (in_ready_m) begin q_m.push_back(exps_q[idx]); q_f.push_back(exps_q[idx]); idx++; end
      if (out_valid_m) begin
        total++;
        if ({result_m, flags_m} !== q_m[0]) begin
          bad++;
          $display("FAIL stall_hold: got %h/%b want %h/%b", result_m, flags_m, q_m[0][34:3], q_m[0][2:0]);
        end
      end
    end
    total++;
    if (idx != 2 || in_ready_m !== 1'b0) begin
      bad++;
      $display("FAIL stall_accept: accepted=%0d in_ready=%b, want 2/0", idx, in_ready_m);
    end
    for (int cyc = 0; cyc < 20 && idx < 3; cyc++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      if (in_ready_m) begin q_m.push_back(exps_q[idx]); q_f.push_back(exps_q[idx]); idx++; end
    end
    wait_drain();
    total++;
    if (idx != 3 || q_m.size() != 0 || q_f.size() != 0) begin
      bad++;
      $display("FAIL drain_b2b: accepted=%0d pending=%0d, want 3/0", idx, q_m.size());
    end
  endtask

  task automatic test_reset_inflight();
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_sign = 1'b0; in_mark = NORM;
      in_prod = 48'h9000_0000_0000; in_exp = 10'd127; in_rmode = 2'd0;
    end
    @(negedge clk);
    total++;
    if (out_valid_m !== 1'b1 || in_ready_m !== 1'b0) begin
      bad++;
      $display("FAIL flight_setup: out_valid=%b in_ready=%b, want 1/0", out_valid_m, in_ready_m);
    end
    @(posedge clk); #2;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    total++;
    if ({out_valid_m, result_m, flags_m, out_valid_f} !== '0 || in_ready_m !== 1'b1) begin
      bad++;
      $display("FAIL flight_reset: v=%b r=%h f=%b in_ready=%b, want 0/0/0/1",
               out_valid_m, result_m, flags_m, in_ready_m);
    end
    q_m.delete();
    q_f.delete();
    @(negedge clk); #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      total++;
      if (out_valid_m !== 1'b0 || out_valid_f !== 1'b0) begin
        bad++;
        $display("FAIL flight_stale: out_valid=%b/%b at cycle %0d, want 0", out_valid_m, out_valid_f, cyc);
      end
    end
    drive(1, 10'd127, 48'h9000_0000_0000, NORM, 2'd0, {32'hC010_0000, 3'b000}, {32'hC010_0000, 3'b000});
    wait_drain();
    total++;
    if (q_m.size() != 0 || q_f.size() != 0) begin
      bad++;
      $display("FAIL drain_flight: pending main=%0d ftz=%0d, want 0", q_m.size(), q_f.size());
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (out_valid_m !== out_valid_f || in_ready_m !== in_ready_f) begin
            total++; bad++;
            $display("FAIL sync: valid %b/%b ready %b/%b, want equal",
                     out_valid_m, out_valid_f, in_ready_m, in_ready_f);
          end
          if (out_valid_m && out_ready) begin
            total++;
            if (q_m.size() == 0) begin
              bad++;
              $display("FAIL out_main: unexpected %h/%b, want no output", result_m, flags_m);
            end else begin
              mon_m = q_m.pop_front();
              if ({result_m, flags_m} !== mon_m) begin
                bad++;
                $display("FAIL out_main: got %h/%b want %h/%b", result_m, flags_m, mon_m[34:3], mon_m[2:0]);
              end
            end
          end
          if (out_valid_f && out_ready) begin
            total++;
            if (q_f.size() == 0) begin
              bad++;
              $display("FAIL out_ftz: unexpected %h/%b, want no output", result_f, flags_f);
            end else begin
              mon_f = q_f.pop_front();
              if ({result_f, flags_f} !== mon_f) begin
                bad++;
                $display("FAIL out_ftz: got %h/%b want %h/%b", result_f, flags_f, mon_f[34:3], mon_f[2:0]);
              end
            end
          end
        end
      end
      begin
        #400000;
        $display("FAIL watchdog: run did not complete, bad=%0d", bad);
        $fatal(1, "watchdog expired");
      end
    join_none
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
